// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES helpers: S-box table, xtime, key-schedule FSM states and sizes
package aes_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int nw(input int nr);
        return 4 * (nr + 1);
    endfunction

    function automatic int nx(input int nk, input int nr);
        return nw(nr) - nk;
    endfunction

endpackage

// File: rtl/key_expansion_seq_if.sv
// rtl/key_expansion_seq_if.sv - request/schedule bundle between key source, key schedule and cipher
interface key_expansion_seq_if #(
    parameter int Nk = 4,
    parameter int Nr = 10
);
    logic                    start;
    logic [32*Nk-1:0]        key;
    logic [128*(Nr+1)-1:0]   word;
    logic                    busy;
    logic                    done;

    modport master (output start, key, input word, busy, done);
    modport slave  (input start, key, output word, busy, done);
endinterface

// File: rtl/sub_word.sv
// rtl/sub_word.sv - SubWord: S-box applied to each byte of a 32-bit word
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};
endmodule

// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - iterative AES key expansion, one schedule word per clock
module key_expansion_seq
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10,
    parameter int N  = 128
) (
    input  logic               clk,
    input  logic               reset,
    key_expansion_seq_if.slave bus
);
    localparam int NW = nw(Nr);
    localparam int WW = 128 * (Nr + 1);
    localparam int CW = $clog2(NW + 1);
    localparam int MW = $clog2(Nk) + 1;

    state_t         r_state, w_next;
    logic           w_load, w_step, w_last;
    logic [CW-1:0]  r_cnt;
    logic [MW-1:0]  r_mod;
    logic [7:0]     r_rcon;
    logic [31:0]    r_win [Nk];
    logic [31:0]    r_w   [NW];
    logic           r_busy, r_done;
    logic [N-1:0]   w_key;
    logic [31:0]    w_prev, w_sub_in, w_sub, w_temp, w_new;
    logic           w_rot_path, w_sub_path;

    assign w_key  = bus.key;
    assign w_last = (r_cnt == CW'(NW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = EXPAND;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (w_last) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // r_win[Nk-1] is w[i-1], r_win[0] is w[i-Nk]; r_mod tracks i mod Nk
    assign w_prev     = r_win[Nk-1];
    assign w_rot_path = (r_mod == '0);
    assign w_sub_path = (Nk > 6) && (r_mod == MW'(4));
    assign w_sub_in   = w_rot_path ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    sub_word u_sub_word (
        .i_word (w_sub_in),
        .o_word (w_sub)
    );

    always_comb begin
        w_temp = w_prev;
        if (w_rot_path)      w_temp = w_sub ^ {r_rcon, 24'h0};
        else if (w_sub_path) w_temp = w_sub;
    end

    assign w_new = r_win[0] ^ w_temp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mod  <= '0;
            r_rcon <= 8'h01;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            for (int j = 0; j < Nk; j++) r_win[j] <= '0;
            for (int j = 0; j < NW; j++) r_w[j]   <= '0;
        end else begin
            if (w_load) begin
                for (int j = 0; j < Nk; j++) begin
                    r_win[j] <= w_key[N-1-32*j -: 32];
                    r_w[j]   <= w_key[N-1-32*j -: 32];
                end
                r_cnt  <= CW'(Nk);
                r_mod  <= '0;
                r_rcon <= 8'h01;
            end else if (w_step) begin
                for (int j = 0; j < NW; j++) begin
                    if (r_cnt == CW'(j)) r_w[j] <= w_new;
                end
                for (int j = 0; j < Nk - 1; j++) r_win[j] <= r_win[j+1];
                r_win[Nk-1] <= w_new;
                r_cnt <= r_cnt + CW'(1);
                r_mod <= (r_mod == MW'(Nk - 1)) ? '0 : r_mod + MW'(1);
                if (w_rot_path) r_rcon <= xtime(r_rcon);
            end
            r_busy <= (w_next == EXPAND);
            r_done <= (w_next == DONE);
        end
    end

    for (genvar j = 0; j < NW; j++) begin : g_word
        assign bus.word[WW-1-32*j -: 32] = r_w[j];
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_key_expansion_seq.sv
// tb/tb_key_expansion_seq.sv - self-checking bench for key_expansion_seq (AES-128/192/256)
module tb_key_expansion_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_expansion_seq_if #(.Nk(4), .Nr(10)) if128 ();
    key_expansion_seq_if #(.Nk(6), .Nr(12)) if192 ();
    key_expansion_seq_if #(.Nk(8), .Nr(14)) if256 ();

    key_expansion_seq #(.Nk(4), .Nr(10), .N(128)) u_dut128 (.clk(clk), .reset(reset), .bus(if128.slave));
    key_expansion_seq #(.Nk(6), .Nr(12), .N(192)) u_dut192 (.clk(clk), .reset(reset), .bus(if192.slave));
    key_expansion_seq #(.Nk(8), .Nr(14), .N(256)) u_dut256 (.clk(clk), .reset(reset), .bus(if256.slave));

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  sb [256];
    logic [7:0]  rc [16];
    logic [31:0] exp_w [60];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int s);
        return (b << s) | (b >> (8 - s));
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    // Reference schedule straight from the FIPS-197 pseudocode
    task automatic model(input int nk, input logic [255:0] k);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) exp_w[i] = k[32*nk-1-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            t = exp_w[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rc[i/nk], 24'h0};
            else if (nk > 6 && i % nk == 4)
                t = subw(t);
            exp_w[i] = exp_w[i-nk] ^ t;
        end
    endtask

    function automatic logic [31:0] get_word(input int v, input int j);
        case (v)
            0:       return if128.word[128*11-1-32*j -: 32];
            1:       return if192.word[128*13-1-32*j -: 32];
            default: return if256.word[128*15-1-32*j -: 32];
        endcase
    endfunction

    function automatic logic get_done(input int v);
        case (v)
            0:       return if128.done;
            1:       return if192.done;
            default: return if256.done;
        endcase
    endfunction

    function automatic logic get_busy(input int v);
        case (v)
            0:       return if128.busy;
            1:       return if192.busy;
            default: return if256.busy;
        endcase
    endfunction

    function automatic logic [127:0] get_rk(input int v, input int r);
        return {get_word(v, 4*r), get_word(v, 4*r+1), get_word(v, 4*r+2), get_word(v, 4*r+3)};
    endfunction

    task automatic set_in(input int v, input logic s, input logic [255:0] k);
        case (v)
            0:       begin if128.start = s; if128.key = k[127:0]; end
            1:       begin if192.start = s; if192.key = k[191:0]; end
            default: begin if256.start = s; if256.key = k;        end
        endcase
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run(input int v, input logic [255:0] k, input int repulse_at,
                       input int abort_at, output int n);
        int nk = 4 + 2 * v;
        int nx = 4 * (nk + 7) - nk;
        bit aborted = 0;
        @(negedge clk);
        set_in(v, 1'b1, k);
        @(posedge clk);
        #1;
        set_in(v, 1'b0, k);
        chk($sformatf("v%0d_done_e0", v), 128'(get_done(v)), 128'd0);
        chk($sformatf("v%0d_busy_e0", v), 128'(get_busy(v)), 128'd1);
        n = 0;
        while (get_done(v) !== 1'b1 && n < 200 && !aborted) begin
            @(posedge clk);
            #1;
            n++;
            if (n == repulse_at)     set_in(v, 1'b1, rand_key());
            if (n == repulse_at + 1) set_in(v, 1'b0, k);
            if (n == abort_at) begin
                reset = 1'b1;
                #2;
                chk("abort_busy", 128'(get_busy(v)), 128'd0);
                chk("abort_done", 128'(get_done(v)), 128'd0);
                chk("abort_rk0", get_rk(v, 0), 128'd0);
                chk("abort_rklast", get_rk(v, nk + 6), 128'd0);
                @(negedge clk);
                reset = 1'b0;
                aborted = 1;
            end
        end
        if (!aborted) begin
            chk($sformatf("v%0d_latency", v), 128'(n), 128'(nx));
            chk($sformatf("v%0d_busy_done", v), 128'(get_busy(v)), 128'd0);
        end
    endtask

    task automatic verify(input int v, input logic [255:0] k, input string tag);
        int nk = 4 + 2 * v;
        model(nk, k);
        for (int r = 0; r <= nk + 6; r++)
            chk($sformatf("%s_rk%0d", tag, r), get_rk(v, r),
                {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]});
    endtask

    initial begin
        int n;
        logic [255:0] k;
        logic [7:0] inv;

        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sb[b] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        rc[0] = 8'h00;
        rc[1] = 8'h01;
        for (int r = 2; r < 16; r++) rc[r] = gmul(rc[r-1], 8'h02);

        for (int v = 0; v < 3; v++) set_in(v, 1'b0, '0);
        #12;
        for (int v = 0; v < 3; v++) begin
            chk($sformatf("v%0d_rst_busy", v), 128'(get_busy(v)), 128'd0);
            chk($sformatf("v%0d_rst_done", v), 128'(get_done(v)), 128'd0);
            chk($sformatf("v%0d_rst_rk0", v), get_rk(v, 0), 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        k = 256'h2b7e151628aed2a6abf7158809cf4f3c;
        run(0, k, -1, -1, n);
        chk("kat128_w4", 128'(get_word(0, 4)), 128'ha0fafe17);
        chk("kat128_rk10", get_rk(0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk("kat128_rk0", get_rk(0, 0), k[127:0]);
        verify(0, k, "kat128");

        k = rand_key();
        run(0, k, 10, -1, n);
        verify(0, k, "repulse");

        k = 256'h000102030405060708090a0b0c0d0e0f;
        run(0, k, -1, -1, n);
        chk("b2b_rk10", get_rk(0, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
        verify(0, k, "b2b");

        k = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
        run(1, k, -1, -1, n);
        chk("kat192_w6", 128'(get_word(1, 6)), 128'hfe0c91f7);
        chk("kat192_w51", 128'(get_word(1, 51)), 128'h01002202);
        verify(1, k, "kat192");

        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run(2, k, -1, -1, n);
        chk("kat256_w8", 128'(get_word(2, 8)), 128'h9ba35411);
        chk("kat256_w59", 128'(get_word(2, 59)), 128'h706c631e);
        verify(2, k, "kat256");

        k = rand_key();
        run(0, k, -1, 20, n);
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", 128'(get_busy(0)), 128'd0);
        chk("post_rst_done", 128'(get_done(0)), 128'd0);
        chk("post_rst_rk0", get_rk(0, 0), 128'd0);
        run(0, k, -1, -1, n);
        verify(0, k, "post_rst");

        for (int v = 0; v < 3; v++) begin
            for (int t = 0; t < 2; t++) begin
                k = rand_key();
                run(v, k, -1, -1, n);
                verify(v, k, $sformatf("rand_v%0d_%0d", v, t));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
